// File: rtl/transmit_packet.sv
// transmit_packet: reads a length-prefixed frame from an Avalon-MM RAM and
// streams it byte by byte, big-endian within each word, into a MAC TX FIFO.
//
// Parameters
//   BASE_ADDR  RAM word address of the length header; payload starts at +1
//   MAX_LEN    largest legal frame length in bytes
// Ports
//   clk_original, rst_n        clock, async active-low reset
//   start                      one-cycle transmit request (accepted only when idle)
//   busy, done, len_err        status: frame in progress / finished / bad header
//   ram_addr, ram_chipselect,
//   ram_read, ram_readdata,
//   ram_waitrequest            Avalon-MM read master
//   ff_tx_data, ff_tx_wren,
//   ff_tx_sop, ff_tx_eop,
//   ff_tx_rdy                  MAC TX FIFO write side
// Build option
//   TX_MIN_PAD_EN  when defined, frames shorter than 60 bytes are padded with
//                  0x00 up to 60 bytes; otherwise exactly length bytes are sent.
module transmit_packet #(
    parameter logic [9:0]  BASE_ADDR = 10'd5,
    parameter logic [11:0] MAX_LEN   = 12'd1024
) (
    input  logic        clk_original,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        len_err,
    output logic [9:0]  ram_addr,
    output logic        ram_chipselect,
    output logic        ram_read,
    input  logic [31:0] ram_readdata,
    input  logic        ram_waitrequest,
    output logic [7:0]  ff_tx_data,
    output logic        ff_tx_wren,
    output logic        ff_tx_sop,
    output logic        ff_tx_eop,
    input  logic        ff_tx_rdy
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_WORD = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              busy_d, done_d, len_err_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic              ram_read_d;
    logic [BYTE_W-1:0] ff_tx_data_d;
    logic              ff_tx_wren_d, ff_tx_sop_d, ff_tx_eop_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              rd_ok;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  nxt_cnt;
    logic [LEN_W-1:0]  last_idx;
    logic [1:0]        sel_nxt;
    logic [BYTE_W-1:0] nxt_byte;

    // Chip select simply mirrors the registered read strobe.
    assign ram_chipselect = ram_read;

    assign rd_ok   = ram_read & ~ram_waitrequest;
    assign hdr_len = ram_readdata[LEN_W-1:0];
    assign nxt_cnt = cnt_q + LEN_W'(1);
    assign sel_nxt = sel_q + 2'd1;

`ifdef TX_MIN_PAD_EN
    localparam logic [LEN_W-1:0] MIN_FRAME = 12'd60;
    // Index of the EOP byte: short frames are stretched to the minimum size.
    assign last_idx = (len_q < MIN_FRAME) ? (MIN_FRAME - LEN_W'(1)) : (len_q - LEN_W'(1));
`else
    assign last_idx = len_q - LEN_W'(1);
`endif

    // Byte following the current one within the holding word, MSB first.
    always_comb begin
        nxt_byte = hold_q[31:24];
        case (sel_nxt)
            2'd0:    nxt_byte = hold_q[31:24];
            2'd1:    nxt_byte = hold_q[23:16];
            2'd2:    nxt_byte = hold_q[15:8];
            default: nxt_byte = hold_q[7:0];
        endcase
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_err    <= 1'b0;
            ram_addr   <= '0;
            ram_read   <= 1'b0;
            ff_tx_data <= '0;
            ff_tx_wren <= 1'b0;
            ff_tx_sop  <= 1'b0;
            ff_tx_eop  <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy       <= busy_d;
            done       <= done_d;
            len_err    <= len_err_d;
            ram_addr   <= ram_addr_d;
            ram_read   <= ram_read_d;
            ff_tx_data <= ff_tx_data_d;
            ff_tx_wren <= ff_tx_wren_d;
            ff_tx_sop  <= ff_tx_sop_d;
            ff_tx_eop  <= ff_tx_eop_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy;
        done_d       = 1'b0;
        len_err_d    = 1'b0;
        ram_addr_d   = ram_addr;
        ram_read_d   = ram_read;
        ff_tx_data_d = ff_tx_data;
        ff_tx_wren_d = ff_tx_wren;
        ff_tx_sop_d  = ff_tx_sop;
        ff_tx_eop_d  = ff_tx_eop;
        len_d        = len_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        hold_d       = hold_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    busy_d     = 1'b1;
                    ram_read_d = 1'b1;
                    ram_addr_d = BASE_ADDR;
                    cnt_d      = '0;
                    sel_d      = '0;
                end
            end

            S_HDR: begin
                if (rd_ok) begin
                    if ((hdr_len == '0) || (hdr_len > MAX_LEN)) begin
                        state_d    = S_IDLE;
                        ram_read_d = 1'b0;
                        busy_d     = 1'b0;
                        len_err_d  = 1'b1;
                    end else begin
                        // Read strobe stays high straight into the first payload read.
                        state_d    = S_WORD;
                        len_d      = hdr_len;
                        ram_addr_d = BASE_ADDR + ADDR_W'(1);
                    end
                end
            end

            S_WORD: begin
                if (rd_ok) begin
                    state_d      = S_SEND;
                    hold_d       = ram_readdata;
                    ram_read_d   = 1'b0;
                    ram_addr_d   = ram_addr + ADDR_W'(1);
                    sel_d        = '0;
                    ff_tx_wren_d = 1'b1;
                    ff_tx_data_d = ram_readdata[31:24];
                    ff_tx_sop_d  = (cnt_q == '0);
                    ff_tx_eop_d  = (cnt_q == last_idx);
                end
            end

            S_SEND: begin
                // Nothing moves until the FIFO takes the presented byte.
                if (ff_tx_rdy) begin
                    cnt_d = nxt_cnt;
                    if (ff_tx_eop) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        ff_tx_wren_d = 1'b0;
                        ff_tx_sop_d  = 1'b0;
                        ff_tx_eop_d  = 1'b0;
`ifdef TX_MIN_PAD_EN
                    end else if (nxt_cnt >= len_q) begin
                        // Payload exhausted: pad with zeros, no further RAM reads.
                        sel_d        = sel_nxt;
                        ff_tx_data_d = '0;
                        ff_tx_sop_d  = 1'b0;
                        ff_tx_eop_d  = (nxt_cnt == last_idx);
`endif
                    end else if (sel_q == 2'd3) begin
                        state_d      = S_WORD;
                        ram_read_d   = 1'b1;
                        ff_tx_wren_d = 1'b0;
                        ff_tx_sop_d  = 1'b0;
                        ff_tx_eop_d  = 1'b0;
                    end else begin
                        sel_d        = sel_nxt;
                        ff_tx_data_d = nxt_byte;
                        ff_tx_sop_d  = 1'b0;
                        ff_tx_eop_d  = (nxt_cnt == last_idx);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                ram_read_d   = 1'b0;
                ff_tx_wren_d = 1'b0;
                ff_tx_sop_d  = 1'b0;
                ff_tx_eop_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_transmit_packet.sv
// Testbench for transmit_packet: RAM slave model with programmable stall,
// FIFO ready patterns, and a byte-stream reference built from the frame rules.
module tb_transmit_packet;

    localparam int unsigned BASE    = 5;
    localparam int          MAX_LEN = 1024;

    logic        clk_original = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, len_err;
    logic [9:0]  ram_addr;
    logic        ram_chipselect, ram_read;
    logic [31:0] ram_readdata;
    logic        ram_waitrequest = 1'b0;
    logic [7:0]  ff_tx_data;
    logic        ff_tx_wren, ff_tx_sop, ff_tx_eop;
    logic        ff_tx_rdy = 1'b1;

    transmit_packet dut (
        .clk_original    (clk_original),
        .rst_n           (rst_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .len_err         (len_err),
        .ram_addr        (ram_addr),
        .ram_chipselect  (ram_chipselect),
        .ram_read        (ram_read),
        .ram_readdata    (ram_readdata),
        .ram_waitrequest (ram_waitrequest),
        .ff_tx_data      (ff_tx_data),
        .ff_tx_wren      (ff_tx_wren),
        .ff_tx_sop       (ff_tx_sop),
        .ff_tx_eop       (ff_tx_eop),
        .ff_tx_rdy       (ff_tx_rdy)
    );

    always #5 clk_original = ~clk_original;

    logic [31:0] mem [0:1023];
    assign ram_readdata = mem[ram_addr];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference stream entries: {sop, eop, data}
    logic [9:0] exp_q [$];
    int  exp_total = 0;
    int  wait_n = 0, rdy_mode = 0, wcnt = 0;
    int  reads = 0, xfers = 0, done_cnt = 0, lenerr_cnt = 0, wren_cycles = 0;
    bit  eop_pend = 0, hold_pend = 0, stall_pend = 0;
    logic [10:0] hold_v;
    logic [9:0]  stall_addr;

    // Drive slave/FIFO inputs for the coming edge, then check what that edge will see.
    always @(negedge clk_original) begin
        if (!rst_n) begin
            wcnt = 0; eop_pend = 0; hold_pend = 0; stall_pend = 0;
            ram_waitrequest = 1'b0;
        end else begin
            if (ram_read && wcnt < wait_n) begin
                ram_waitrequest = 1'b1; wcnt++;
            end else begin
                ram_waitrequest = 1'b0; wcnt = 0;
            end
            case (rdy_mode)
                0:       ff_tx_rdy = 1'b1;
                1:       ff_tx_rdy = ~ff_tx_rdy;
                default: ff_tx_rdy = 1'($urandom_range(0, 1));
            endcase

            if (stall_pend) begin
                chk("ram_read_held", 32'(ram_read), 32'd1);
                chk("ram_addr_held", 32'(ram_addr), 32'(stall_addr));
            end
            stall_pend = ram_read && ram_waitrequest;
            stall_addr = ram_addr;
            if (ram_read || ram_chipselect)
                chk("ram_chipselect", 32'(ram_chipselect), 32'(ram_read));
            if (ram_read && !ram_waitrequest) begin
                chk("ram_addr", 32'(ram_addr), 32'((BASE + 32'(reads)) % 1024));
                reads++;
            end

            if (hold_pend)
                chk("tx_hold", 32'({ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_data}), 32'(hold_v));
            hold_pend = ff_tx_wren && !ff_tx_rdy;
            hold_v    = {ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_data};

            if (eop_pend || done) begin
                chk("done_after_eop", 32'(done), 32'(eop_pend));
                if (done) done_cnt++;
            end
            eop_pend = 0;
            if (len_err) lenerr_cnt++;
            if (ff_tx_wren) wren_cycles++;

            if (ff_tx_wren && ff_tx_rdy) begin
                xfers++;
                if (exp_q.size() == 0)
                    chk("byte_count", 32'(xfers), 32'(exp_total));
                else
                    chk("tx_byte", 32'({ff_tx_sop, ff_tx_eop, ff_tx_data}), 32'(exp_q.pop_front()));
                eop_pend = ff_tx_eop;
            end
        end
    end

    task automatic fill_mem(input int len);
        logic [31:0] hdr;
        hdr = $urandom();
        hdr[11:0] = 12'(len);
        mem[BASE] = hdr;
        for (int i = 0; i < 300; i++) mem[(BASE + 1 + i) % 1024] = $urandom();
    endtask

    // Expected byte stream from header length and RAM contents.
    task automatic build_exp(input int len);
        int n;
        logic [31:0] w;
        logic [7:0]  b;
        exp_q.delete();
        n = (len >= 1 && len <= MAX_LEN) ? len : 0;
`ifdef TX_MIN_PAD_EN
        if (n > 0 && n < 60) n = 60;
`endif
        for (int i = 0; i < n; i++) begin
            if (i < len) begin
                w = mem[(BASE + 1 + i / 4) % 1024];
                b = 8'(w >> (8 * (3 - i % 4)));
            end else begin
                b = 8'h00;
            end
            exp_q.push_back({i == 0, i == n - 1, b});
        end
        exp_total = n;
        reads = 0; xfers = 0; done_cnt = 0; lenerr_cnt = 0; wren_cycles = 0;
    endtask

    task automatic go(input int len, input bit mid_start, input bit start_on_done);
        int  cyc;
        bit  legal;
        legal = (len >= 1 && len <= MAX_LEN);
        @(negedge clk_original) start = 1'b1;
        @(negedge clk_original) start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (!(done || len_err) && cyc < 20000) begin
            @(negedge clk_original);
            cyc++;
            start = (mid_start && cyc == 6);
        end
        chk("frame_timeout", 32'(cyc < 20000), 32'd1);
        if (start_on_done) begin
            start = 1'b1;
            @(negedge clk_original) start = 1'b0;
            chk("start_on_done_ignored", 32'({busy, ram_read}), 32'd0);
        end
        repeat (3) @(negedge clk_original);
        chk("bytes_left", 32'(exp_q.size()), 32'd0);
        chk("byte_count", 32'(xfers), 32'(exp_total));
        chk("done_pulses", 32'(done_cnt), legal ? 32'd1 : 32'd0);
        chk("len_err_pulses", 32'(lenerr_cnt), legal ? 32'd0 : 32'd1);
        chk("ram_reads", 32'(reads), legal ? 32'((len + 3) / 4 + 1) : 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        if (!legal) chk("wren_on_err", 32'(wren_cycles), 32'd0);
    endtask

    task automatic run_frame(input int len, input int wn, input int rm,
                             input bit mid_start, input bit start_on_done);
        wait_n = wn; rdy_mode = rm;
        fill_mem(len);
        build_exp(len);
        go(len, mid_start, start_on_done);
    endtask

    initial begin
        int cyc, len;
        // Reset state
        repeat (2) @(negedge clk_original);
        chk("reset_outputs", 32'({busy, done, len_err, ram_read, ram_chipselect, ff_tx_wren,
                                  ff_tx_sop, ff_tx_eop, ram_addr, ff_tx_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_original);

        // Directed 5-byte frame with known payload
        wait_n = 0; rdy_mode = 0;
        fill_mem(5);
        mem[BASE + 1] = 32'h11223344;
        mem[BASE + 2] = 32'h55AABBCC;
        build_exp(5);
        go(5, 1'b0, 1'b0);

        // Illegal headers
        run_frame(0, 0, 0, 1'b0, 1'b0);
        run_frame(1025, 1, 2, 1'b0, 1'b0);

        // Stalled reads with toggling FIFO ready
        run_frame(8, 3, 1, 1'b0, 1'b0);

        // Reset in the middle of a frame
        wait_n = 0; rdy_mode = 0;
        fill_mem(4);
        build_exp(4);
        @(negedge clk_original) start = 1'b1;
        @(negedge clk_original) start = 1'b0;
        cyc = 0;
        while (xfers < 2 && cyc < 100) begin
            @(negedge clk_original);
            cyc++;
        end
        chk("reset_wait_timeout", 32'(cyc < 100), 32'd1);
        @(posedge clk_original);
        #2 rst_n = 1'b0;
        #1 chk("midframe_reset_outputs", 32'({busy, done, len_err, ram_read, ram_chipselect, ff_tx_wren,
                                             ff_tx_sop, ff_tx_eop, ram_addr, ff_tx_data}), 32'd0);
        repeat (2) @(negedge clk_original);
        rst_n = 1'b1;
        run_frame(4, 0, 0, 1'b0, 1'b0);

        // Start while busy and start coincident with done
        run_frame(20, 1, 2, 1'b1, 1'b1);

        // Length boundaries
        run_frame(1, 0, 0, 1'b0, 1'b1);
        run_frame(MAX_LEN, 0, 2, 1'b0, 1'b0);

        // Randomised frames
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 80);
            run_frame(len, $urandom_range(0, 3), $urandom_range(0, 2),
                      (len >= 16) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
